rv32i_dmem_bridge: RTL
======================

RV32I_DMEM_BRIDGE -- requirements
Module: rv32i_dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a transaction may hold o_wb_cyc before abort.
REQ-002 Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
REQ-003 i_clk  in  1  system clock.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_rd_mem  in  1  load request from memory-access stage.
REQ-006 i_wr_mem  in  1  store request from memory-access stage.
REQ-007 i_addr  in  32  byte address from ALU.
REQ-008 i_data_store  in  32  mask-aligned store data.
REQ-009 i_wr_mask  in  4  byte write mask {b3,b2,b1,b0}.
REQ-010 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone B4 pipelined control.
REQ-011 o_wb_addr  out  30  word address, i_addr[31:2].
REQ-012 o_wb_data  out  32  write data; o_wb_sel  out  4  byte select.
REQ-013 i_wb_ack, i_wb_stall  in  1 each  slave acknowledge / stall.
REQ-014 i_wb_data  in  32  read data from slave.
REQ-015 o_din  out  32  raw loaded word to memory-access stage.
REQ-016 o_stall  out  1  holds pipeline while a transaction is pending.
REQ-017 o_done  out  1  one-cycle pulse: transaction completed.
REQ-018 o_bus_err  out  1  one-cycle pulse: transaction aborted by timeout.

Function
REQ-019 FSM SHALL have states IDLE, REQ, WAIT.
REQ-020 In IDLE with i_rd_mem|i_wr_mem = 1 in cycle N, SHALL latch addr/data/mask; o_wb_cyc=o_wb_stb=1 from cycle N+1; state -> REQ.
REQ-021 i_wr_mem and i_rd_mem both high: store SHALL win; o_wb_we=1.
REQ-022 Loads: o_wb_sel=4'b1111, o_wb_we=0; stores: o_wb_sel=latched i_wr_mask, o_wb_data=latched i_data_store.
REQ-023 REQ: o_wb_stb held with address/data/sel stable while i_wb_stall=1; when i_wb_stall=0, stb drops next cycle, state -> WAIT.
REQ-024 i_wb_ack in REQ while i_wb_stall=0 SHALL complete the transaction directly (skip WAIT).
REQ-025 Completion on i_wb_ack in cycle M: cycle M+1 has o_wb_cyc=0, state IDLE, o_done=1; for loads o_din=i_wb_data sampled at M, held until next load completes.
REQ-026 i_wb_ack in IDLE SHALL be ignored.
REQ-027 o_stall = request present in IDLE OR state != IDLE (combinational); low in cycle M+1.
REQ-028 8-bit-wide-enough counter SHALL reset to 0 on each accept, increment each cycle in REQ/WAIT; reaching TIMEOUT without ack: cyc/stb drop next cycle, o_bus_err=1 one cycle, o_din unchanged, state IDLE, o_done=0.
REQ-029 Ack and timeout in same cycle: ack SHALL win.
REQ-030 New request SHALL be accepted in the first IDLE cycle after completion (back-to-back, one idle bus cycle between).
REQ-031 Requests while state != IDLE SHALL be ignored (stage is held by o_stall).

Reset
REQ-032 On i_rst_n=0: state IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_bus_err = 0; o_wb_addr, o_wb_data, o_wb_sel, o_din, counter = 0.
REQ-033 Reset mid-transaction SHALL abandon it with no o_done/o_bus_err pulse; o_stall reflects only inputs afterward.

Structure
REQ-034 State encodings and TIMEOUT default SHALL live in the shared rv32i package header.
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 Load, addr 0x0000_1004, slave acks 2 cycles after stb, i_wb_data=0xDEAD_BEEF -> o_wb_addr=0x401, sel=1111, o_din=0xDEADBEEF with o_done pulse, o_stall low same cycle.
REQ-037 Store, addr 0x0000_0022, mask 0100, data 0x00AB_0000, i_wb_stall=1 for 3 cycles -> stb held 4 cycles, addr/data/sel stable, we=1, o_done after ack.
REQ-038 Slave never acks, TIMEOUT=8 -> cyc drops after 8 cycles, o_bus_err single pulse, o_din unchanged.
REQ-039 Both i_rd_mem and i_wr_mem high -> o_wb_we=1, sel=i_wr_mask.
REQ-040 i_rst_n low during WAIT -> all outputs 0 asynchronously, no o_done; next request proceeds normally.
REQ-041 Two back-to-back loads with zero-wait ack -> second stb exactly one idle cycle after first completion; both o_din values correct.

Source files
------------

// File: rtl/rv32i_dmem_bridge_pkg.sv
// Shared definitions for the RV32I data-memory Wishbone bridge:
// FSM state encoding, default abort timeout and the byte-select rule.
package rv32i_dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } bridge_state_e;

    // Cycles a transaction may hold the bus before it is aborted.
    localparam int DMEM_TIMEOUT = 255;

    // Loads always fetch the full word; stores use the stage's byte mask.
    function automatic logic [3:0] wb_sel(input logic is_store, input logic [3:0] mask);
        return is_store ? mask : 4'b1111;
    endfunction

endpackage

// File: rtl/rv32i_dmem_bridge.sv
// RV32I memory-stage to Wishbone B4 pipelined master bridge.
// One outstanding transaction at a time; the pipeline is frozen through
// o_stall until the slave acks or the cycle counter hits TIMEOUT.
module rv32i_dmem_bridge
    import rv32i_dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd_mem,
    input  logic        i_wr_mem,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_store,
    input  logic [3:0]  i_wr_mask,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_din,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_bus_err
);

    // At least 8 bits, wider only if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The counter holds k-1 during the k-th bus cycle, so this value marks the last allowed cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bridge_state_e    state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      din_q, din_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Byte offset is implied by the select lines; word address drops it.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_addr[1:0];

    // Next-state and registered-output logic for the bus FSM.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Acks seen here belong to nothing and are dropped.
                if (i_rd_mem || i_wr_mem) begin
                    addr_d  = i_addr[31:2];
                    wdata_d = i_data_store;
                    we_d    = i_wr_mem;
                    sel_d   = wb_sel(i_wr_mem, i_wr_mask);
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is only meaningful once the strobe has been accepted.
                if (i_wb_ack && (state_q == ST_WAIT || !i_wb_stall)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (!we_q) din_d = i_wb_data;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_REQ && !i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset abandons any transaction silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = wdata_q;
    assign o_wb_sel  = sel_q;
    assign o_din     = din_q;
    assign o_done    = done_q;
    assign o_bus_err = err_q;
    // Freeze the stage as soon as it asks, and for as long as the bus is busy.
    assign o_stall   = (state_q == ST_IDLE) ? (i_rd_mem | i_wr_mem) : 1'b1;

endmodule
